// File: rtl/decode_stage_pipe.sv
// RV32I decode stage: combinational decode into a registered output slot backed by one skid entry.
// Optional macro RV32M_DECODE_EN accepts RV32M (func7=0000001) R-type encodings and flags them as mul/div.
module decode_stage_pipe #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_func3,
  output logic [6:0]      out_func7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic            out_is_muldiv,
  output logic [PC_W-1:0] out_pc
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_SYS = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic            is_muldiv;
  } dec_t;

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        base_f7_ok;
  logic        shift_f7_ok;
  logic        muldiv_enc;
  logic [31:0] imm32;
  logic        bad;
  dec_t        dec_next;

  assign op = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];

  // 0100000 is only meaningful for sub/sra (R) and srai (shift-immediate, func3=101).
  assign base_f7_ok  = (f7 == 7'b0000000) ||
                       ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
  assign shift_f7_ok = (f7 == 7'b0000000) || ((f7 == 7'b0100000) && (f3 == 3'b101));

`ifdef RV32M_DECODE_EN
  assign muldiv_enc = (f7 == 7'b0000001);
`else
  assign muldiv_enc = 1'b0;
`endif

  always_comb begin
    dec_next        = '0;
    dec_next.opcode = op;
    imm32           = 32'd0;
    bad             = 1'b0;
    case (op)
      OP_R: begin
        dec_next.fmt       = FMT_R;
        dec_next.rs1       = in_instr[19:15];
        dec_next.rs2       = in_instr[24:20];
        dec_next.rd        = in_instr[11:7];
        dec_next.func3     = f3;
        dec_next.func7     = f7;
        dec_next.is_muldiv = muldiv_enc;
        bad                = !(base_f7_ok || muldiv_enc);
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        dec_next.fmt   = FMT_I;
        dec_next.rs1   = in_instr[19:15];
        dec_next.rd    = in_instr[11:7];
        dec_next.func3 = f3;
        imm32          = {{20{in_instr[31]}}, in_instr[31:20]};
        if (op == OP_IMM && (f3 == 3'b001 || f3 == 3'b101)) begin
          dec_next.func7 = f7;
          bad            = !shift_f7_ok;
        end else if (op == OP_LOAD) begin
          bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end else if (op == OP_JALR) begin
          bad = (f3 != 3'b000);
        end
      end
      OP_STORE: begin
        dec_next.fmt   = FMT_S;
        dec_next.rs1   = in_instr[19:15];
        dec_next.rs2   = in_instr[24:20];
        dec_next.func3 = f3;
        imm32          = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        bad            = (f3 >= 3'b011);
      end
      OP_BRANCH: begin
        dec_next.fmt   = FMT_B;
        dec_next.rs1   = in_instr[19:15];
        dec_next.rs2   = in_instr[24:20];
        dec_next.func3 = f3;
        imm32          = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
        bad            = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OP_LUI, OP_AUIPC: begin
        dec_next.fmt = FMT_U;
        dec_next.rd  = in_instr[11:7];
        imm32        = {in_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        dec_next.fmt = FMT_J;
        dec_next.rd  = in_instr[11:7];
        imm32        = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                        in_instr[20], in_instr[30:21], 1'b0};
      end
      OP_SYSTEM: begin
        dec_next.fmt   = FMT_SYS;
        dec_next.func3 = f3;
        imm32          = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      default: bad = 1'b1;
    endcase
    dec_next.imm = XLEN'($signed(imm32));
    // Illegal entries keep only the opcode; execute traps on the flag and the carried PC.
    if (bad) begin
      dec_next         = '0;
      dec_next.opcode  = op;
      dec_next.fmt     = FMT_ILL;
      dec_next.illegal = 1'b1;
    end
  end

  dec_t            out_reg, out_next;
  dec_t            skid_reg, skid_next;
  logic [PC_W-1:0] out_pc_reg, out_pc_next;
  logic [PC_W-1:0] skid_pc_reg, skid_pc_next;
  logic            out_valid_reg, out_valid_next;
  logic            skid_valid_reg, skid_valid_next;
  logic            in_ready_reg, in_ready_next;
  logic            accept;
  logic            out_free;

  assign accept   = in_valid && in_ready_reg;
  assign out_free = !out_valid_reg || out_ready;

  always_comb begin
    out_next        = out_reg;
    out_pc_next     = out_pc_reg;
    out_valid_next  = out_valid_reg;
    skid_next       = skid_reg;
    skid_pc_next    = skid_pc_reg;
    skid_valid_next = skid_valid_reg;
    if (flush) begin
      out_valid_next  = 1'b0;
      skid_valid_next = 1'b0;
    end else if (out_free) begin
      // The skid entry is older than anything arriving now, so it drains first.
      if (skid_valid_reg) begin
        out_next        = skid_reg;
        out_pc_next     = skid_pc_reg;
        out_valid_next  = 1'b1;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        out_next       = dec_next;
        out_pc_next    = in_pc;
        out_valid_next = 1'b1;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (accept) begin
      skid_next       = dec_next;
      skid_pc_next    = in_pc;
      skid_valid_next = 1'b1;
    end
    in_ready_next = !skid_valid_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg        <= '0;
      skid_reg       <= '0;
      out_pc_reg     <= '0;
      skid_pc_reg    <= '0;
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b0;
    end else begin
      out_reg        <= out_next;
      skid_reg       <= skid_next;
      out_pc_reg     <= out_pc_next;
      skid_pc_reg    <= skid_pc_next;
      out_valid_reg  <= out_valid_next;
      skid_valid_reg <= skid_valid_next;
      in_ready_reg   <= in_ready_next;
    end
  end

  assign in_ready      = in_ready_reg;
  assign out_valid     = out_valid_reg;
  assign out_opcode    = out_reg.opcode;
  assign out_rs1       = out_reg.rs1;
  assign out_rs2       = out_reg.rs2;
  assign out_rd        = out_reg.rd;
  assign out_func3     = out_reg.func3;
  assign out_func7     = out_reg.func7;
  assign out_imm       = out_reg.imm;
  assign out_fmt       = out_reg.fmt;
  assign out_illegal   = out_reg.illegal;
  assign out_is_muldiv = out_reg.is_muldiv;
  assign out_pc        = out_pc_reg;

endmodule
